// File: rtl/irq_controller.sv
// Interrupt sequencer: edge-latched requests, fixed-priority take into a handler,
// resume-PC save/restore on rti, and a cause word for rdi.
module irq_controller #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               inst_valid,
  input  logic               stall,
  input  logic               rsi,
  input  logic [PC_W-1:0]    rsi_data,
  input  logic               rti,
  input  logic [PC_W-1:0]    resume_pc,
  output logic               int_take,
  output logic [PC_W-1:0]    int_vector,
  output logic               ret_take,
  output logic [PC_W-1:0]    ret_pc,
  output logic               int_active,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [31:0]        cause
);

  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_SRC-1:0] irq_req_q;
  logic [NUM_SRC-1:0] pending;
  logic               enabled;
  logic [SEL_W-1:0]   sel;
  logic               rsi_acc;
  logic               rti_dec;
  logic               take_ok;
  logic               ret_ok;
  logic               int_take_d;
  logic               ret_take_d;
  logic [NUM_SRC-1:0] irq_ack_d;

  assign rsi_acc = rsi & inst_valid & ~stall;
  assign rti_dec = rti & inst_valid;
  assign take_ok = enabled & (|pending) & ~stall & ~rti_dec;
  assign ret_ok  = rti_dec & ~stall;

  // Lowest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending[i]) sel = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // RETURN is a one-cycle blackout and leaves even under stall.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (take_ok) state_next = ST_ACTIVE;
      ST_ACTIVE: if (ret_ok)  state_next = ST_RETURN;
      ST_RETURN: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    int_take_d = 1'b0;
    ret_take_d = 1'b0;
    irq_ack_d  = '0;
    case (state)
      ST_IDLE: begin
        if (take_ok) begin
          int_take_d = 1'b1;
          irq_ack_d  = NUM_SRC'(1) << sel;
        end
      end
      ST_ACTIVE: ret_take_d = ret_ok;
      default: ;
    endcase
  end

  // Datapath registers; a new edge on the clearing clock keeps the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req_q  <= '0;
      pending    <= '0;
      enabled    <= 1'b0;
      int_vector <= '0;
      ret_pc     <= '0;
      cause      <= '0;
      int_take   <= 1'b0;
      ret_take   <= 1'b0;
      irq_ack    <= '0;
      int_active <= 1'b0;
    end else begin
      irq_req_q  <= irq_req;
      pending    <= (pending & ~irq_ack) | (irq_req & ~irq_req_q);
      int_take   <= int_take_d;
      ret_take   <= ret_take_d;
      irq_ack    <= irq_ack_d;
      int_active <= (state_next == ST_ACTIVE);
      if (rsi_acc) begin
        int_vector <= rsi_data;
        enabled    <= (rsi_data != '0);
      end
      if (int_take_d) begin
        ret_pc <= resume_pc;
        cause  <= 32'h8000_0000 | 32'(sel);
      end
      if (ret_take_d) cause[31] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic
// compared against a behavioural model of the interrupt rules.
module tb_irq_controller;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned PC_W    = 32;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_req;
  logic               inst_valid;
  logic               stall;
  logic               rsi;
  logic [PC_W-1:0]    rsi_data;
  logic               rti;
  logic [PC_W-1:0]    resume_pc;
  logic               int_take;
  logic [PC_W-1:0]    int_vector;
  logic               ret_take;
  logic [PC_W-1:0]    ret_pc;
  logic               int_active;
  logic [NUM_SRC-1:0] irq_ack;
  logic [31:0]        cause;

  int n_checks = 0;
  int n_pass   = 0;

  irq_controller #(.NUM_SRC(NUM_SRC), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .inst_valid(inst_valid),
    .stall(stall), .rsi(rsi), .rsi_data(rsi_data), .rti(rti),
    .resume_pc(resume_pc), .int_take(int_take), .int_vector(int_vector),
    .ret_take(ret_take), .ret_pc(ret_pc), .int_active(int_active),
    .irq_ack(irq_ack), .cause(cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a handler flag and a blackout flag instead of a state machine.
  logic [NUM_SRC-1:0] m_prev, m_pend, m_ack;
  logic [PC_W-1:0]    m_vec, m_epc;
  logic [31:0]        m_cause;
  logic               m_en, m_in_handler, m_blackout, m_int_take, m_ret_take;

  always @(posedge clk or negedge rst_n) begin : model
    int  sel;
    logic take, ret;
    if (!rst_n) begin
      m_prev <= '0; m_pend <= '0; m_ack <= '0; m_vec <= '0; m_epc <= '0;
      m_cause <= '0; m_en <= 1'b0; m_in_handler <= 1'b0; m_blackout <= 1'b0;
      m_int_take <= 1'b0; m_ret_take <= 1'b0;
    end else begin
      sel = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (m_pend[i]) sel = i;
      take = !m_in_handler && !m_blackout && m_en && (m_pend != 0) && !stall
             && !(rti && inst_valid);
      ret  = m_in_handler && rti && inst_valid && !stall;
      m_prev     <= irq_req;
      m_pend     <= (m_pend & ~m_ack) | (irq_req & ~m_prev);
      m_int_take <= take;
      m_ret_take <= ret;
      m_ack      <= take ? (NUM_SRC'(1) << sel) : '0;
      m_blackout <= ret;
      if (take) begin
        m_epc        <= resume_pc;
        m_cause      <= 32'h8000_0000 + 32'(sel);
        m_in_handler <= 1'b1;
      end
      if (ret) begin
        m_in_handler <= 1'b0;
        m_cause[31]  <= 1'b0;
      end
      if (rsi && inst_valid && !stall) begin
        m_vec <= rsi_data;
        m_en  <= (rsi_data != 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; irq_req = '0; inst_valid = 1'b0; stall = 1'b0; rsi = 1'b0;
    rsi_data = '0; rti = 1'b0; resume_pc = '0;
    #1 rst_n = 1'b0;
    step(); step();
    n_checks++; if (int_take !== 1'b0) $display("FAIL reset_int_take got=%b exp=0", int_take); else n_pass++;
    n_checks++; if (ret_take !== 1'b0) $display("FAIL reset_ret_take got=%b exp=0", ret_take); else n_pass++;
    n_checks++; if (int_active !== 1'b0) $display("FAIL reset_int_active got=%b exp=0", int_active); else n_pass++;
    n_checks++; if (irq_ack !== 4'b0) $display("FAIL reset_irq_ack got=%b exp=0000", irq_ack); else n_pass++;
    n_checks++; if (int_vector !== 32'h0) $display("FAIL reset_vector got=%h exp=0", int_vector); else n_pass++;
    n_checks++; if (ret_pc !== 32'h0) $display("FAIL reset_ret_pc got=%h exp=0", ret_pc); else n_pass++;
    n_checks++; if (cause !== 32'h0) $display("FAIL reset_cause got=%h exp=0", cause); else n_pass++;
    rst_n = 1'b1;
    inst_valid = 1'b1;
    step();
  endtask

  task automatic test_basic_take();
    rsi = 1'b1; rsi_data = 32'h0000_0400;
    step();
    rsi = 1'b0; irq_req = 4'b0100; resume_pc = 32'h100;
    step();
    n_checks++; if (int_take !== 1'b0) $display("FAIL basic_early_take got=%b exp=0", int_take); else n_pass++;
    step();
    n_checks++; if (int_take !== 1'b1) $display("FAIL basic_take got=%b exp=1", int_take); else n_pass++;
    n_checks++; if (int_vector !== 32'h400) $display("FAIL basic_vector got=%h exp=400", int_vector); else n_pass++;
    n_checks++; if (irq_ack !== 4'b0100) $display("FAIL basic_ack got=%b exp=0100", irq_ack); else n_pass++;
    n_checks++; if (cause !== 32'h8000_0002) $display("FAIL basic_cause got=%h exp=80000002", cause); else n_pass++;
    n_checks++; if (ret_pc !== 32'h100) $display("FAIL basic_ret_pc got=%h exp=100", ret_pc); else n_pass++;
    resume_pc = 32'h180;
    step();
    n_checks++; if ({int_take, irq_ack} !== 5'b0) $display("FAIL basic_pulse_len take=%b ack=%b exp=0", int_take, irq_ack); else n_pass++;
    n_checks++; if (int_active !== 1'b1) $display("FAIL basic_active got=%b exp=1", int_active); else n_pass++;
  endtask

  task automatic test_return();
    rti = 1'b1;
    step();
    rti = 1'b0;
    n_checks++; if (ret_take !== 1'b1) $display("FAIL ret_take got=%b exp=1", ret_take); else n_pass++;
    n_checks++; if (ret_pc !== 32'h100) $display("FAIL ret_pc got=%h exp=100", ret_pc); else n_pass++;
    n_checks++; if (int_active !== 1'b0) $display("FAIL ret_active got=%b exp=0", int_active); else n_pass++;
    n_checks++; if (cause !== 32'h0000_0002) $display("FAIL ret_cause got=%h exp=00000002", cause); else n_pass++;
    irq_req = '0;
    step();
    n_checks++; if ({ret_take, int_take} !== 2'b00) $display("FAIL ret_pulse_len ret=%b take=%b exp=00", ret_take, int_take); else n_pass++;
    step();
  endtask

  task automatic test_priority();
    irq_req = 4'b1010;
    step();
    step();
    n_checks++; if (irq_ack !== 4'b0010) $display("FAIL prio_first_ack got=%b exp=0010", irq_ack); else n_pass++;
    n_checks++; if (cause !== 32'h8000_0001) $display("FAIL prio_first_cause got=%h exp=80000001", cause); else n_pass++;
    irq_req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (int_take !== 1'b0) $display("FAIL prio_nesting cyc=%0d take=%b exp=0", i, int_take); else n_pass++;
    end
    rti = 1'b1;
    step();
    rti = 1'b0;
    step();
    n_checks++; if (int_take !== 1'b0) $display("FAIL prio_blackout take=%b exp=0", int_take); else n_pass++;
    step();
    n_checks++; if (irq_ack !== 4'b0001) $display("FAIL prio_second_ack got=%b exp=0001", irq_ack); else n_pass++;
    n_checks++; if (cause !== 32'h8000_0000) $display("FAIL prio_second_cause got=%h exp=80000000", cause); else n_pass++;
    rti = 1'b1;
    step();
    rti = 1'b0;
    step();
    step();
    n_checks++; if (irq_ack !== 4'b1000) $display("FAIL prio_third_ack got=%b exp=1000", irq_ack); else n_pass++;
    n_checks++; if (cause !== 32'h8000_0003) $display("FAIL prio_third_cause got=%h exp=80000003", cause); else n_pass++;
    rti = 1'b1;
    step();
    rti = 1'b0; irq_req = '0;
    step(); step();
  endtask

  task automatic test_disabled();
    rsi = 1'b1; rsi_data = '0;
    step();
    rsi = 1'b0; irq_req = 4'b0001;
    step();
    irq_req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (int_take !== 1'b0) $display("FAIL dis_no_take cyc=%0d take=%b exp=0", i, int_take); else n_pass++;
    end
    rsi = 1'b1; rsi_data = 32'h200;
    step();
    rsi = 1'b0;
    n_checks++; if (int_vector !== 32'h200) $display("FAIL dis_vector got=%h exp=200", int_vector); else n_pass++;
    step();
    n_checks++; if ({int_take, irq_ack} !== 5'b1_0001) $display("FAIL dis_take take=%b ack=%b exp=1/0001", int_take, irq_ack); else n_pass++;
    rti = 1'b1;
    step();
    rti = 1'b0;
    step();
    rsi = 1'b1; rsi_data = '0;
    step();
    rsi = 1'b0; irq_req = 4'b0010;
    step();
    irq_req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (int_take !== 1'b0) $display("FAIL dis_rsi0 cyc=%0d take=%b exp=0", i, int_take); else n_pass++;
    end
  endtask

  task automatic test_stall();
    rsi = 1'b1; rsi_data = 32'h300;
    step();
    rsi = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (int_take !== 1'b0) $display("FAIL stall_take cyc=%0d take=%b exp=0", i, int_take); else n_pass++;
    end
    stall = 1'b0;
    step();
    n_checks++; if ({int_take, irq_ack} !== 5'b1_0010) $display("FAIL stall_release take=%b ack=%b exp=1/0010", int_take, irq_ack); else n_pass++;
    rti = 1'b1;
    step();
    rti = 1'b0;
    step(); step();
    rti = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if ({ret_take, int_active} !== 2'b00) $display("FAIL rti_idle cyc=%0d ret=%b act=%b exp=00", i, ret_take, int_active); else n_pass++;
    end
    rti = 1'b0;
  endtask

  task automatic test_reset_mid();
    irq_req = 4'b0100; resume_pc = 32'h2468;
    step();
    step();
    n_checks++; if (int_take !== 1'b1) $display("FAIL rmid_setup take=%b exp=1", int_take); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({int_take, ret_take, int_active, irq_ack} !== 7'b0) $display("FAIL rmid_pulses take=%b ret=%b act=%b ack=%b exp=0", int_take, ret_take, int_active, irq_ack); else n_pass++;
    n_checks++; if ({int_vector, ret_pc, cause} !== 96'b0) $display("FAIL rmid_regs vec=%h pc=%h cause=%h exp=0", int_vector, ret_pc, cause); else n_pass++;
    step();
    irq_req = '0; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if ({int_take, ret_take, int_active} !== 3'b0) $display("FAIL rmid_idle cyc=%0d take=%b ret=%b act=%b exp=000", i, int_take, ret_take, int_active); else n_pass++;
    end
    rsi = 1'b1; rsi_data = 32'h500;
    step();
    rsi = 1'b0;
    step(); step();
    n_checks++; if (int_take !== 1'b0) $display("FAIL rmid_pending_clr take=%b exp=0", int_take); else n_pass++;
    irq_req = 4'b1000;
    step(); step();
    n_checks++; if ({int_take, irq_ack} !== 5'b1_1000) $display("FAIL rmid_after take=%b ack=%b exp=1/1000", int_take, irq_ack); else n_pass++;
    rti = 1'b1;
    step();
    rti = 1'b0; irq_req = '0;
    step(); step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int b = 0; b < NUM_SRC; b++) if ($urandom_range(9) == 0) irq_req[b] = ~irq_req[b];
      stall      = ($urandom_range(4) == 0);
      inst_valid = ($urandom_range(4) != 0);
      rti        = ($urandom_range(6) == 0);
      rsi        = ($urandom_range(19) == 0);
      rsi_data   = ($urandom_range(3) == 0) ? 32'h0 : {$urandom_range(32'hFFFF), 2'b00};
      resume_pc  = $urandom;
      step();
      n_checks++;
      if ({int_take, ret_take, int_active, irq_ack} !== {m_int_take, m_ret_take, m_in_handler, m_ack}
          || {int_vector, ret_pc, cause} !== {m_vec, m_epc, m_cause})
        $display("FAIL rand cyc=%0d got take=%b ret=%b act=%b ack=%b vec=%h pc=%h cause=%h exp take=%b ret=%b act=%b ack=%b vec=%h pc=%h cause=%h",
                 cyc, int_take, ret_take, int_active, irq_ack, int_vector, ret_pc, cause,
                 m_int_take, m_ret_take, m_in_handler, m_ack, m_vec, m_epc, m_cause);
      else n_pass++;
      n_checks++; if (int_take && ret_take) $display("FAIL rand_exclusive cyc=%0d take=%b ret=%b exp not both", cyc, int_take, ret_take); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_take();
    test_return();
    test_priority();
    test_disabled();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
